reg_dump_controller: RTL

//  Debug sequencer for the decode stage's register bank. When the pipeline is halted, it takes over

---
 rtl/debug_pkg.sv | 20 ++
 rtl/word_serializer.sv | 71 +++++++
 rtl/reg_dump_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: dump FSM states, byte width and
// word-to-byte helper. The debug command decoder imports this package too.
package debug_pkg;

    localparam int NB_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_PC,
        SETTLE,
        SEND_REG,
        DONE
    } dump_state_e;

    // Number of bytes needed to carry one word of nb_data bits.
    function automatic int BYTES_PER_WORD(input int nb_data);
        return nb_data / NB_BYTE;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads one NB_DATA-bit word and emits it least-significant byte first over
// valid/ready. last_o marks the final byte of the word. Also used by the
// memory-dump controller.
module word_serializer
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [NB_DATA-1:0] data_i,
    input  logic               ready_i,
    output logic [NB_BYTE-1:0] byte_o,
    output logic               valid_o,
    output logic               last_o
);

    localparam int NUM_BYTES = BYTES_PER_WORD(NB_DATA);
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               valid_q, valid_d;

    // Next-state: clear beats load, load beats shifting on a handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (cnt_q == LAST_CNT) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                shift_d = shift_q >> NB_BYTE;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: the shift register is reset too, so tx data is a defined 0 right after reset.
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign byte_o  = shift_q[NB_BYTE-1:0];
    assign valid_o = valid_q;
    assign last_o  = valid_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/reg_dump_controller.sv
// Debug register-bank dump sequencer. While the pipeline is halted it owns
// bank read port A, walks every register and streams the PC byte followed by
// all register values (LSB first) to the debug UART transmitter.
module reg_dump_controller
    import debug_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_PC    = 7,
    parameter int READ_LAT = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               dump_start_i,
    input  logic               halted_i,
    input  logic [NB_PC-1:0]   pc_i,
    input  logic [NB_DATA-1:0] data_ra_i,
    output logic               select_debug_or_wireA_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               abort_o
);

    localparam logic [NB_REG-1:0] LAST_IDX = '1;
    localparam int SETTLE_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(READ_LAT - 1);

    dump_state_e         state_q,  state_d;
    logic [NB_REG-1:0]   idx_q,    idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [NB_PC-1:0]    pc_q,     pc_d;
    logic                abort_q,  abort_d;

    logic               halt_lost;
    logic               ser_load;
    logic               ser_ready;
    logic               ser_valid;
    logic               ser_last;
    logic [NB_BYTE-1:0] ser_byte;

    // Losing the halt anywhere outside IDLE abandons the dump at the next edge.
    assign halt_lost = (state_q != IDLE) && !halted_i;
    assign ser_ready = tx_ready_i && (state_q == SEND_REG);

    word_serializer #(
        .NB_DATA (NB_DATA)
    ) u_word_serializer (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load_i  (ser_load),
        .clear_i (halt_lost),
        .data_i  (data_ra_i),
        .ready_i (ser_ready),
        .byte_o  (ser_byte),
        .valid_o (ser_valid),
        .last_o  (ser_last)
    );

    // Next-state logic: abort has priority over the normal dump sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        pc_d     = pc_q;
        abort_d  = 1'b0;
        ser_load = 1'b0;
        if (halt_lost) begin
            state_d  = IDLE;
            abort_d  = 1'b1;
            idx_d    = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_start_i && halted_i) begin
                        state_d = SEND_PC;
                        pc_d    = pc_i;
                    end
                end
                SEND_PC: begin
                    if (tx_ready_i) begin
                        state_d  = SETTLE;
                        idx_d    = '0;
                        settle_d = '0;
                    end
                end
                SETTLE: begin
                    // Address has been stable READ_LAT cycles: bank data is valid now.
                    if (settle_q == SETTLE_LAST) begin
                        ser_load = 1'b1;
                        settle_d = '0;
                        state_d  = SEND_REG;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                SEND_REG: begin
                    if (ser_last && tx_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = SETTLE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, register index, settle counter, latched PC and abort pulse.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            pc_q     <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            pc_q     <= pc_d;
            abort_q  <= abort_d;
        end
    end

    assign select_debug_or_wireA_o = (state_q == SETTLE) || (state_q == SEND_REG) ||
                                     (state_q == DONE);
    assign addr_reg_debug_o = idx_q;
    assign tx_valid_o       = (state_q == SEND_PC) || ((state_q == SEND_REG) && ser_valid);
    assign tx_data_o        = (state_q == SEND_PC)  ? NB_BYTE'(pc_q) :
                              (state_q == SEND_REG) ? ser_byte : '0;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign abort_o          = abort_q;

endmodule
